// File: rtl/mem_responder_if.sv
// CPU-side memory bus: the initiator drives requests, the responder answers
// with a one-cycle completion pulse and error flags.
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        err_addr;
  logic        err_proto;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata, err_addr, err_proto
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata, err_addr, err_proto
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed on-chip memory acting as the responder of the CPU memory bus,
// with fixed configurable latency, byte-enable writes and error flagging.
module mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_is_write;
  logic                  r_oor;
  logic                  r_req_rd;
  logic                  r_req_wr;
  logic [31:0]           r_req_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;
  logic [ADDR_BITS-1:0]  r_idx;
  logic                  r_resp;
  logic                  r_err_addr;
  logic                  r_err_proto;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_req;
  logic                  w_oor;
  logic [ADDR_BITS-1:0]  w_idx;
  logic                  w_changed;
  logic                  w_go_resp;
  logic                  w_nx_read;
  logic                  w_nx_oor;
  logic [ADDR_BITS-1:0]  w_nx_idx;
  logic                  w_commit;

  assign w_req     = bus.mem_read | bus.mem_write;
  assign w_oor     = bus.mem_address[31:ADDR_BITS+2] != '0;
  assign w_idx     = bus.mem_address[ADDR_BITS+1:2];
  assign w_changed = (bus.mem_read != r_req_rd) || (bus.mem_write != r_req_wr) ||
                     (bus.mem_address != r_req_addr);

  // RESP is entered either straight from IDLE (LATENCY==1) or at the end of
  // WAIT; the read-side controls come from the bus or the latch accordingly.
  assign w_go_resp = ((r_state == IDLE) && w_req && (LATENCY == 1)) ||
                     ((r_state == WAIT) && (r_cnt == 4'd1));
  assign w_nx_read = (r_state == IDLE) ? bus.mem_read : !r_is_write;
  assign w_nx_oor  = (r_state == IDLE) ? w_oor        : r_oor;
  assign w_nx_idx  = (r_state == IDLE) ? w_idx        : r_idx;

  assign w_commit  = (r_state == RESP) && r_is_write && !r_oor && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_is_write  <= 1'b0;
      r_oor       <= 1'b0;
      r_resp      <= 1'b0;
      r_rdata     <= '0;
      r_err_addr  <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      r_resp     <= 1'b0;
      r_err_addr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_is_write <= !bus.mem_read;
            r_oor      <= w_oor;
            r_idx      <= w_idx;
            r_wdata    <= bus.mem_wdata;
            r_be       <= bus.mem_byte_enable;
            r_req_rd   <= bus.mem_read;
            r_req_wr   <= bus.mem_write;
            r_req_addr <= bus.mem_address;
            r_cnt      <= CNT_INIT;
            r_state    <= (LATENCY == 1) ? RESP : WAIT;
            if (bus.mem_read && bus.mem_write) r_err_proto <= 1'b1;
          end
        end
        WAIT: begin
          if (w_changed) r_err_proto <= 1'b1;
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= RESP;
        end
        RESP: begin
          if (w_changed) r_err_proto <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_go_resp) begin
        r_resp     <= 1'b1;
        r_err_addr <= w_nx_oor;
        if (w_nx_read) r_rdata <= w_nx_oor ? 32'h0 : r_mem[w_nx_idx];
      end
    end
  end

  // NOTE: storage is deliberately not reset; only the control path clears,
  // which keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign bus.mem_resp  = r_resp;
  assign bus.mem_rdata = r_rdata;
  assign bus.err_addr  = r_err_addr;
  assign bus.err_proto = r_err_proto;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a transaction-level model schedules the
// expected response per cycle and a compare process checks every cycle.
module tb_mem_responder;
  localparam int LAT  = 2;
  localparam int NCYC = 1024;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en = 1'b0;

  mem_responder_if bus ();
  mem_responder_if bus1 ();

  mem_responder #(.ADDR_BITS(10), .LATENCY(LAT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_responder #(.ADDR_BITS(10), .LATENCY(1)) u_dut_lat1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected events, indexed by cycle number
  bit          exp_resp  [NCYC];
  bit          exp_isrd  [NCYC];
  bit          exp_eaddr [NCYC];
  logic [31:0] exp_val   [NCYC];
  bit          ev_proto  [NCYC];
  bit          ev_reset  [NCYC];

  logic [31:0] mm [int];
  logic        m_proto = 1'b0;
  logic [31:0] m_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic sched(input int n, input bit isrd, input logic [31:0] v, input bit ea);
    exp_resp[n]  = 1'b1;
    exp_isrd[n]  = isrd;
    exp_val[n]   = v;
    exp_eaddr[n] = ea;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int k;
    k = int'(addr[11:2]);
    if (addr[31:12] != 0) return 32'h0;
    return mm.exists(k) ? mm[k] : 32'h0;
  endfunction

  always @(negedge clk) begin
    if (chk_en && cyc < NCYC) begin
      if (ev_reset[cyc]) begin
        m_proto = 1'b0;
        m_rdata = 32'h0;
      end
      if (ev_proto[cyc]) m_proto = 1'b1;
      if (exp_resp[cyc] && exp_isrd[cyc]) m_rdata = exp_val[cyc];
      check("mem_resp",  {31'b0, bus.mem_resp},  {31'b0, exp_resp[cyc]});
      check("err_addr",  {31'b0, bus.err_addr},  {31'b0, exp_eaddr[cyc]});
      check("mem_rdata", bus.mem_rdata, m_rdata);
      check("err_proto", {31'b0, bus.err_proto}, {31'b0, m_proto});
    end
  end

  // Issue one request at the current cycle (DUT idle) and hold it to mem_resp.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input bit chg, input bit chk_lit, input logic [31:0] lit);
    int          c;
    bit          oor;
    logic [31:0] w;
    c   = cyc;
    oor = addr[31:12] != 0;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_wdata       = wdata;
    bus.mem_byte_enable = be;
    if (rd) begin
      sched(c + LAT, 1'b1, model_read(addr), oor);
      if (wr) ev_proto[c + 1] = 1'b1;
    end else begin
      if (!oor) begin
        w = model_read(addr);
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
        mm[int'(addr[11:2])] = w;
      end
      sched(c + LAT, 1'b0, 32'h0, oor);
    end
    @(posedge clk); #1;
    if (chg) begin
      bus.mem_address = addr ^ 32'h4;
      ev_proto[c + 2] = 1'b1;
    end
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    if (chk_lit) check("lit_rdata", bus.mem_rdata, lit);
    @(posedge clk); #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    ev_reset[cyc + 1] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic reset_mid_write();
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b1;
    bus.mem_address     = 32'h10;
    bus.mem_wdata       = 32'h12345678;
    bus.mem_byte_enable = 4'hF;
    @(posedge clk); #1;
    reset_pulse();
    bus.mem_write = 1'b0;
    @(negedge clk);
    check("rst_resp",      {31'b0, bus.mem_resp},  32'h0);
    check("rst_rdata",     bus.mem_rdata,          32'h0);
    check("rst_err_addr",  {31'b0, bus.err_addr},  32'h0);
    check("rst_err_proto", {31'b0, bus.err_proto}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_byte_enable = 4'h0;
    bus.mem_address = 32'h0; bus.mem_wdata = 32'h0;
    bus1.mem_read = 1'b0; bus1.mem_write = 1'b0; bus1.mem_byte_enable = 4'h0;
    bus1.mem_address = 32'h0; bus1.mem_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_resp",      {31'b0, bus.mem_resp},  32'h0);
    check("reset_rdata",     bus.mem_rdata,          32'h0);
    check("reset_err_proto", {31'b0, bus.err_proto}, 32'h0);
    @(posedge clk); #1;

    do_req(0, 1, 32'h0,    32'hCAFEF00D, 4'hF, 0, 0, 32'h0);
    do_req(0, 1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 0, 32'h0);
    do_req(1, 0, 32'h10,   32'h0,        4'h0, 0, 1, 32'hDEADBEEF);
    do_req(0, 1, 32'h10,   32'h00AA0000, 4'b0100, 0, 0, 32'h0);
    do_req(1, 0, 32'h10,   32'h0,        4'h0, 0, 1, 32'hDEAABEEF);
    do_req(0, 1, 32'h10,   32'hFFFFFFFF, 4'h0, 0, 0, 32'h0);
    do_req(1, 0, 32'h10,   32'h0,        4'h0, 0, 1, 32'hDEAABEEF);
    do_req(1, 0, 32'h1000, 32'h0,        4'h0, 0, 1, 32'h0);
    do_req(0, 1, 32'h1000, 32'h11111111, 4'hF, 0, 0, 32'h0);
    do_req(1, 0, 32'h0,    32'h0,        4'h0, 0, 1, 32'hCAFEF00D);

    reset_mid_write();
    do_req(1, 0, 32'h10, 32'h0, 4'h0, 0, 1, 32'hDEAABEEF);

    do_req(1, 0, 32'h10, 32'h0, 4'h0, 1, 1, 32'hDEAABEEF);
    @(negedge clk);
    check("lit_proto_addr_change", {31'b0, bus.err_proto}, 32'h1);
    @(posedge clk); #1;

    reset_pulse();
    do_req(1, 1, 32'h10, 32'h0, 4'hF, 0, 1, 32'hDEAABEEF);
    do_req(1, 0, 32'h10, 32'h0, 4'h0, 0, 1, 32'hDEAABEEF);
    @(negedge clk);
    check("lit_proto_both_high", {31'b0, bus.err_proto}, 32'h1);
    @(posedge clk); #1;

    // Held read at LATENCY=2: completions every three cycles
    begin
      int c;
      c = cyc;
      bus.mem_read    = 1'b1;
      bus.mem_address = 32'h10;
      for (int k = 0; k < 3; k++) sched(c + LAT + 3*k, 1'b1, model_read(32'h10), 1'b0);
      repeat (9) @(posedge clk);
      #1;
      bus.mem_read = 1'b0;
    end

    // Held read at LATENCY=1: completions every other cycle
    bus1.mem_read    = 1'b1;
    bus1.mem_address = 32'h20;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      check("lat1_resp", {31'b0, bus1.mem_resp}, {31'b0, (k % 2) == 1});
    end
    check("lat1_err_proto", {31'b0, bus1.err_proto}, 32'h0);
    @(posedge clk); #1;
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
